// File: rtl/stream_pacer_fifo.sv
// stream_pacer_fifo: valid/ready input stream buffered in a small FIFO and
// re-emitted as single-cycle enable_o strobes, with a programmable minimum
// number of idle cycles between consecutive strobes.
module stream_pacer_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int GAP_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [GAP_WIDTH-1:0]       gap_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [WIDTH-1:0]           s_data_i,
    output logic                       enable_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        count_q, count_d;
    state_t               state_q;
    // Holds the gap latched at the last pop; counts down while in GAP.
    logic [GAP_WIDTH-1:0] gap_cnt_q;
    logic                 enable_q;
    logic [WIDTH-1:0]     data_q;

    logic empty, full, push, pop_req, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));

    // Ready looks only at registered occupancy, so a pop never feeds ready
    // combinationally; a freed slot shows up one cycle after the pop.
    assign s_ready_o = !full && !rst_i && !flush_i;
    assign push      = s_valid_i && s_ready_o;

    // Pop decision comes from registered state/count only, so a word written
    // on this edge cannot be emitted on the same edge.
    always_comb begin
        pop_req = 1'b0;
        case (state_q)
            IDLE:    pop_req = !empty;
            EMIT:    pop_req = (gap_cnt_q == '0) && !empty;
            GAP:     pop_req = (gap_cnt_q <= GAP_WIDTH'(1)) && !empty;
            default: pop_req = 1'b0;
        endcase
    end
    assign pop = pop_req && !flush_i;

    // Next occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
    end

    // Storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracked separately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Pacing FSM with registered strobe/data; data only moves with a pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            enable_q  <= 1'b0;
            data_q    <= '0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            enable_q  <= 1'b0;
        end else begin
            enable_q <= pop;
            if (pop) begin
                data_q    <= mem_q[rd_ptr_q];
                gap_cnt_q <= gap_i;
                state_q   <= EMIT;
            end else begin
                case (state_q)
                    EMIT: begin
                        if (gap_cnt_q == '0) state_q <= IDLE;
                        else                 state_q <= GAP;
                    end
                    GAP: begin
                        // Last idle cycle: behave as IDLE (pop handled above).
                        if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                            gap_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign enable_o = enable_q;
    assign data_o   = data_q;
    assign level_o  = count_q;

endmodule

// File: tb/tb_stream_pacer_fifo.sv
// Directed bench for stream_pacer_fifo: reset, latency, back-to-back,
// pacing with mid-gap gap_i change, backpressure, flush and async reset.
module tb_stream_pacer_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic [3:0] gap_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] s_data_i;
    logic       enable_o;
    logic [7:0] data_o;
    logic [2:0] level_o;

    int n_cmp = 0;
    int n_err = 0;

    stream_pacer_fifo #(.WIDTH(8), .DEPTH(4), .GAP_WIDTH(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .gap_i     (gap_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .enable_o  (enable_o),
        .data_o    (data_o),
        .level_o   (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int sent, rcv, cyc, last, pulses;
        logic acc;
        logic [7:0] exp_d;
        logic exp_en;
        logic [2:0] exp_lv;

        rst_i = 1'b1; flush_i = 1'b0; gap_i = 4'd0;
        s_valid_i = 1'b0; s_data_i = 8'h00;

        // 1. reset / idle
        repeat (3) step();
        chk("rst_ready", 32'(s_ready_o), 32'd0);
        chk("rst_en", 32'(enable_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", 32'(s_ready_o), 32'd1);
        chk("post_rst_en", 32'(enable_o), 32'd0);
        chk("post_rst_data", 32'(data_o), 32'h00);
        chk("post_rst_level", 32'(level_o), 32'd0);

        // 2. single word, gap 0: strobe exactly in the cycle after edge k+1
        s_valid_i = 1'b1; s_data_i = 8'hA5;
        step();
        s_valid_i = 1'b0;
        chk("t2_lvl_k", 32'(level_o), 32'd1);
        chk("t2_en_k", 32'(enable_o), 32'd0);
        step();
        chk("t2_en_k1", 32'(enable_o), 32'd1);
        chk("t2_data_k1", 32'(data_o), 32'hA5);
        chk("t2_lvl_k1", 32'(level_o), 32'd0);
        step();
        chk("t2_en_k2", 32'(enable_o), 32'd0);
        chk("t2_hold", 32'(data_o), 32'hA5);

        // 3. back-to-back with gap 0
        s_valid_i = 1'b1; s_data_i = 8'h01;
        step();
        chk("t3_en_e1", 32'(enable_o), 32'd0);
        s_data_i = 8'h02;
        step();
        chk("t3_en1", 32'(enable_o), 32'd1); chk("t3_d1", 32'(data_o), 32'h01);
        s_data_i = 8'h03;
        step();
        chk("t3_en2", 32'(enable_o), 32'd1); chk("t3_d2", 32'(data_o), 32'h02);
        s_data_i = 8'h04;
        step();
        chk("t3_en3", 32'(enable_o), 32'd1); chk("t3_d3", 32'(data_o), 32'h03);
        s_valid_i = 1'b0;
        step();
        chk("t3_en4", 32'(enable_o), 32'd1); chk("t3_d4", 32'(data_o), 32'h04);
        step();
        chk("t3_en_end", 32'(enable_o), 32'd0);
        chk("t3_lvl_end", 32'(level_o), 32'd0);

        // 4. pacing gap 3; gap_i forced to 0 for two edges mid-gap
        for (int i = 1; i <= 13; i++) begin
            s_valid_i = (i <= 3);
            s_data_i  = 8'h10 + 8'(i - 1);
            gap_i     = (i == 4 || i == 5) ? 4'd0 : 4'd3;
            step();
            exp_en = (i == 2 || i == 6 || i == 10);
            exp_d  = (i >= 10) ? 8'h12 : (i >= 6) ? 8'h11 : (i >= 2) ? 8'h10 : 8'h04;
            exp_lv = (i >= 10) ? 3'd0 : (i >= 6) ? 3'd1 : (i >= 3) ? 3'd2 : 3'd1;
            chk($sformatf("t4_en_%0d", i), 32'(enable_o), 32'(exp_en));
            chk($sformatf("t4_d_%0d", i), 32'(data_o), 32'(exp_d));
            chk($sformatf("t4_lv_%0d", i), 32'(level_o), 32'(exp_lv));
        end
        s_valid_i = 1'b0;
        repeat (2) step();

        // 5. backpressure, gap 15, six words with valid held
        gap_i = 4'd15;
        sent = 0; rcv = 0; cyc = 0; last = 0; pulses = 0;
        while (rcv < 6 && cyc < 200) begin
            s_valid_i = (sent < 6);
            s_data_i  = 8'h20 + 8'(sent);
            #1;
            acc = s_valid_i && s_ready_o;
            step();
            cyc++;
            if (acc) sent++;
            chk("t5_lvl_max", 32'(level_o <= 3'd4), 32'd1);
            chk("t5_ready_full", 32'(s_ready_o), 32'(level_o != 3'd4));
            if (level_o == 3'd4) pulses++;
            if (enable_o) begin
                chk($sformatf("t5_data_%0d", rcv), 32'(data_o), 32'(8'h20 + 8'(rcv)));
                if (rcv > 0) chk($sformatf("t5_spacing_%0d", rcv), 32'(cyc - last), 32'd16);
                last = cyc;
                rcv++;
            end
        end
        chk("t5_received", 32'(rcv), 32'd6);
        chk("t5_accepted", 32'(sent), 32'd6);
        chk("t5_saw_full", 32'(pulses > 0), 32'd1);
        s_valid_i = 1'b0;
        repeat (18) step();

        // 6. flush while in GAP with level 3, then async reset mid-EMIT
        for (int i = 0; i < 4; i++) begin
            s_valid_i = 1'b1; s_data_i = 8'h30 + 8'(i);
            step();
        end
        s_valid_i = 1'b0;
        chk("t6_lvl3", 32'(level_o), 32'd3);
        flush_i = 1'b1; s_valid_i = 1'b1; s_data_i = 8'h99;
        #1;
        chk("t6_flush_ready", 32'(s_ready_o), 32'd0);
        step();
        flush_i = 1'b0; s_valid_i = 1'b0;
        chk("t6_flush_lvl", 32'(level_o), 32'd0);
        chk("t6_flush_en", 32'(enable_o), 32'd0);
        chk("t6_flush_data", 32'(data_o), 32'h30);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (enable_o) pulses++;
        end
        chk("t6_no_pulses", 32'(pulses), 32'd0);
        chk("t6_lvl_after", 32'(level_o), 32'd0);

        gap_i = 4'd0;
        s_valid_i = 1'b1; s_data_i = 8'h5A;
        step();
        s_valid_i = 1'b0;
        step();
        chk("t6_emit_en", 32'(enable_o), 32'd1);
        chk("t6_emit_data", 32'(data_o), 32'h5A);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_async_en", 32'(enable_o), 32'd0);
        chk("t6_async_data", 32'(data_o), 32'h00);
        chk("t6_async_lvl", 32'(level_o), 32'd0);
        chk("t6_async_ready", 32'(s_ready_o), 32'd0);
        repeat (2) step();
        rst_i = 1'b0;
        #1;
        chk("t6_rel_ready", 32'(s_ready_o), 32'd1);
        chk("t6_rel_lvl", 32'(level_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
